// File: rtl/mem_arbiter.sv
// Arbitrates one single-port unified memory between instruction fetch and the MEM stage.
// Data wins ties; each access takes WAIT_CYCLES+1 memory cycles and ends with a one-cycle ready.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        IfReq,
    input  logic [31:0] IfAddr,
    output logic [31:0] IfRdata,
    output logic        IfReady,
    input  logic        DReq,
    input  logic        DWe,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWdata,
    output logic [31:0] DRdata,
    output logic        DReady,
    output logic [31:0] MemAddr,
    output logic        MemWe,
    output logic [31:0] MemWdata,
    input  logic [31:0] MemRdata,
    output logic        StallF,
    output logic        StallM,
    output logic        BusyD
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE_I,
        DONE_D
    } arbState_e;

    arbState_e   state;
    arbState_e   stateNext;
    logic [3:0]  cnt;
    logic [3:0]  cntNext;
    logic [31:0] addrReg;
    logic [31:0] addrNext;
    logic        weReg;
    logic        weNext;
    logic [31:0] wdataReg;
    logic [31:0] wdataNext;
    logic [31:0] ifRdataReg;
    logic [31:0] ifRdataNext;
    logic [31:0] dRdataReg;
    logic [31:0] dRdataNext;

    // Request fields are latched at grant so requester changes mid-access are harmless.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addrReg    <= 32'd0;
            weReg      <= 1'b0;
            wdataReg   <= 32'd0;
            ifRdataReg <= 32'd0;
            dRdataReg  <= 32'd0;
        end else begin
            state      <= stateNext;
            cnt        <= cntNext;
            addrReg    <= addrNext;
            weReg      <= weNext;
            wdataReg   <= wdataNext;
            ifRdataReg <= ifRdataNext;
            dRdataReg  <= dRdataNext;
        end
    end

    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        addrNext    = addrReg;
        weNext      = weReg;
        wdataNext   = wdataReg;
        ifRdataNext = ifRdataReg;
        dRdataNext  = dRdataReg;
        case (state)
            IDLE: begin
                // The MEM stage holds the older instruction, so it is served first.
                if (DReq) begin
                    addrNext  = DAddr;
                    weNext    = DWe;
                    wdataNext = DWdata;
                    cntNext   = WAIT_LOAD;
                    stateNext = BUSY_D;
                end else if (IfReq) begin
                    addrNext  = IfAddr;
                    weNext    = 1'b0;
                    cntNext   = WAIT_LOAD;
                    stateNext = BUSY_I;
                end
            end
            BUSY_I: begin
                if (cnt != 4'd0) begin
                    cntNext = cnt - 4'd1;
                end else begin
                    ifRdataNext = MemRdata;
                    stateNext   = DONE_I;
                end
            end
            BUSY_D: begin
                if (cnt != 4'd0) begin
                    cntNext = cnt - 4'd1;
                end else begin
                    if (!weReg) begin
                        dRdataNext = MemRdata;
                    end
                    stateNext = DONE_D;
                end
            end
            DONE_I:  stateNext = IDLE;
            DONE_D:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Write strobe only on the final access cycle of a store.
    assign MemWe    = (state == BUSY_D) && (cnt == 4'd0) && weReg;
    assign MemAddr  = addrReg & ~32'h3;
    assign MemWdata = wdataReg;
    assign IfReady  = (state == DONE_I);
    assign DReady   = (state == DONE_D);
    assign IfRdata  = ifRdataReg;
    assign DRdata   = dRdataReg;
    assign StallF   = IfReq & ~IfReady;
    assign StallM   = DReq & ~DReady;
    assign BusyD    = (state == BUSY_D) || (state == DONE_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instances with WAIT_CYCLES 0, 1 and 2, each with its own memory model.
module tb_mem_arbiter;

    logic        CLK;
    logic        reset    [3];
    logic        ifReq    [3];
    logic [31:0] ifAddr   [3];
    logic [31:0] ifRdata  [3];
    logic        ifReady  [3];
    logic        dReq     [3];
    logic        dWe      [3];
    logic [31:0] dAddr    [3];
    logic [31:0] dWdata   [3];
    logic [31:0] dRdata   [3];
    logic        dReady   [3];
    logic [31:0] memAddr  [3];
    logic        memWe    [3];
    logic [31:0] memWdata [3];
    logic [31:0] memRdata [3];
    logic        stallF   [3];
    logic        stallM   [3];
    logic        busyD    [3];

    int testsRun  = 0;
    int failCount = 0;

    function automatic logic [31:0] initWord(input int i);
        return 32'h2000_0000 | (32'(i) << 16) | 32'(2 * i + 1);
    endfunction

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 3; g++) begin : gen
        logic [31:0] mem [64];

        initial begin
            for (int i = 0; i < 64; i++) mem[i] = initWord(i);
        end

        always @(posedge CLK) begin
            if (memWe[g]) mem[memAddr[g][7:2]] <= memWdata[g];
        end

        assign memRdata[g] = mem[memAddr[g][7:2]];

        mem_arbiter #(.WAIT_CYCLES(g)) dut (
            .CLK      (CLK),
            .Reset    (reset[g]),
            .IfReq    (ifReq[g]),
            .IfAddr   (ifAddr[g]),
            .IfRdata  (ifRdata[g]),
            .IfReady  (ifReady[g]),
            .DReq     (dReq[g]),
            .DWe      (dWe[g]),
            .DAddr    (dAddr[g]),
            .DWdata   (dWdata[g]),
            .DRdata   (dRdata[g]),
            .DReady   (dReady[g]),
            .MemAddr  (memAddr[g]),
            .MemWe    (memWe[g]),
            .MemWdata (memWdata[g]),
            .MemRdata (memRdata[g]),
            .StallF   (stallF[g]),
            .StallM   (stallM[g]),
            .BusyD    (busyD[g])
        );
    end

    typedef struct {
        logic        rst;
        logic        ifReq;
        logic [31:0] ifAddr;
        logic        dReq;
        logic        dWe;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        logic        expIfReady;
        logic        expDReady;
        logic        expMemWe;
        logic [31:0] expMemAddr;
        logic        expStallF;
        logic        expStallM;
        logic        expBusyD;
        logic [31:0] expIfRdata;
        logic [31:0] expDRdata;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset[1]  = v.rst;
        ifReq[1]  = v.ifReq;
        ifAddr[1] = v.ifAddr;
        dReq[1]   = v.dReq;
        dWe[1]    = v.dWe;
        dAddr[1]  = v.dAddr;
        dWdata[1] = v.dWdata;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        localparam logic [31:0] D = 32'hDEAD_BEEF;
        localparam logic [31:0] F = 32'h2002_0005;
        localparam logic [31:0] L = 32'h2001_0003;
        localparam logic [31:0] S = 32'h1234_5678;

        for (int g = 0; g < 3; g++) begin
            reset[g] = 1'b1; ifReq[g] = 1'b0; ifAddr[g] = '0; dReq[g] = 1'b0;
            dWe[g] = 1'b0; dAddr[g] = '0; dWdata[g] = '0;
        end
        tick();
        tick();
        for (int g = 0; g < 3; g++) reset[g] = 1'b0;

        // Quiet period after reset on the WAIT_CYCLES=1 instance.
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput($sformatf("idle%0d memWe", i), 32'(memWe[1]), 32'd0);
            checkOutput($sformatf("idle%0d ifReady", i), 32'(ifReady[1]), 32'd0);
            checkOutput($sformatf("idle%0d dReady", i), 32'(dReady[1]), 32'd0);
            checkOutput($sformatf("idle%0d ifRdata", i), ifRdata[1], 32'd0);
            checkOutput($sformatf("idle%0d dRdata", i), dRdata[1], 32'd0);
            tick();
        end

        //          rst if  ifAddr  dq we dAddr  dWdata    ifR dR mWe memAddr sF sM bD ifRdata dRdata
        vecs.push_back('{1, 0, 32'h0,  0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,  0, 0, 0, 32'h0, 32'h0});
        vecs.push_back('{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,  0, 0, 0, 32'h0, 32'h0});
        vecs.push_back('{0, 1, 32'h8,  0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h0,  1, 0, 0, 32'h0, 32'h0});
        vecs.push_back('{0, 1, 32'h8,  0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h8,  1, 0, 0, 32'h0, 32'h0});
        vecs.push_back('{0, 1, 32'h8,  0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h8,  1, 0, 0, 32'h0, 32'h0});
        vecs.push_back('{0, 1, 32'h8,  0, 0, 32'h0,  32'h0,    1, 0, 0, 32'h8,  0, 0, 0, F,     32'h0});
        vecs.push_back('{0, 0, 32'h8,  0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h8,  0, 0, 0, F,     32'h0});
        vecs.push_back('{0, 0, 32'h0,  1, 1, 32'h54, D,        0, 0, 0, 32'h8,  0, 1, 0, F,     32'h0});
        vecs.push_back('{0, 0, 32'h0,  1, 1, 32'h54, D,        0, 0, 0, 32'h54, 0, 1, 1, F,     32'h0});
        vecs.push_back('{0, 0, 32'h0,  1, 1, 32'h54, D,        0, 0, 1, 32'h54, 0, 1, 1, F,     32'h0});
        vecs.push_back('{0, 0, 32'h0,  1, 1, 32'h54, D,        0, 1, 0, 32'h54, 0, 0, 1, F,     32'h0});
        vecs.push_back('{0, 0, 32'h0,  1, 0, 32'h57, 32'h0,    0, 0, 0, 32'h54, 0, 1, 0, F,     32'h0});
        vecs.push_back('{0, 0, 32'h0,  1, 0, 32'h57, 32'h0,    0, 0, 0, 32'h54, 0, 1, 1, F,     32'h0});
        vecs.push_back('{0, 0, 32'h0,  1, 0, 32'h57, 32'h0,    0, 0, 0, 32'h54, 0, 1, 1, F,     32'h0});
        vecs.push_back('{0, 0, 32'h0,  1, 0, 32'h57, 32'h0,    0, 1, 0, 32'h54, 0, 0, 1, F,     D});
        vecs.push_back('{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h54, 0, 0, 0, F,     D});
        vecs.push_back('{0, 1, 32'h4,  1, 1, 32'h10, S,        0, 0, 0, 32'h54, 1, 1, 0, F,     D});
        vecs.push_back('{0, 1, 32'h4,  1, 1, 32'h10, S,        0, 0, 0, 32'h10, 1, 1, 1, F,     D});
        vecs.push_back('{0, 1, 32'h4,  1, 1, 32'h10, S,        0, 0, 1, 32'h10, 1, 1, 1, F,     D});
        vecs.push_back('{0, 1, 32'h4,  1, 1, 32'h10, S,        0, 1, 0, 32'h10, 1, 0, 1, F,     D});
        vecs.push_back('{0, 1, 32'h4,  0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h10, 1, 0, 0, F,     D});
        vecs.push_back('{0, 1, 32'h4,  0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h4,  1, 0, 0, F,     D});
        vecs.push_back('{0, 1, 32'h4,  0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h4,  1, 0, 0, F,     D});
        vecs.push_back('{0, 1, 32'h4,  0, 0, 32'h0,  32'h0,    1, 0, 0, 32'h4,  0, 0, 0, L,     D});
        vecs.push_back('{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h4,  0, 0, 0, L,     D});
        vecs.push_back('{0, 0, 32'h0,  1, 0, 32'h10, 32'h0,    0, 0, 0, 32'h4,  0, 1, 0, L,     D});
        vecs.push_back('{0, 0, 32'h0,  1, 0, 32'h10, 32'h0,    0, 0, 0, 32'h10, 0, 1, 1, L,     D});
        vecs.push_back('{0, 0, 32'h0,  1, 0, 32'h10, 32'h0,    0, 0, 0, 32'h10, 0, 1, 1, L,     D});
        vecs.push_back('{0, 0, 32'h0,  1, 0, 32'h10, 32'h0,    0, 1, 0, 32'h10, 0, 0, 1, L,     S});
        vecs.push_back('{0, 0, 32'h0,  0, 0, 32'h0,  32'h0,    0, 0, 0, 32'h10, 0, 0, 0, L,     S});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d ifReady", i), 32'(ifReady[1]), 32'(vecs[i].expIfReady));
            checkOutput($sformatf("v%0d dReady", i), 32'(dReady[1]), 32'(vecs[i].expDReady));
            checkOutput($sformatf("v%0d memWe", i), 32'(memWe[1]), 32'(vecs[i].expMemWe));
            checkOutput($sformatf("v%0d memAddr", i), memAddr[1], vecs[i].expMemAddr);
            checkOutput($sformatf("v%0d stallF", i), 32'(stallF[1]), 32'(vecs[i].expStallF));
            checkOutput($sformatf("v%0d stallM", i), 32'(stallM[1]), 32'(vecs[i].expStallM));
            checkOutput($sformatf("v%0d busyD", i), 32'(busyD[1]), 32'(vecs[i].expBusyD));
            checkOutput($sformatf("v%0d ifRdata", i), ifRdata[1], vecs[i].expIfRdata);
            checkOutput($sformatf("v%0d dRdata", i), dRdata[1], vecs[i].expDRdata);
            if (vecs[i].expMemWe) begin
                checkOutput($sformatf("v%0d memWdata", i), memWdata[1], vecs[i].dWdata);
            end
            tick();
        end

        // Simultaneous requests, WAIT_CYCLES=0: data first, fetch after the next IDLE.
        begin
            int dCyc = -1;
            int iCyc = -1;
            logic [31:0] dData = '0;
            logic [31:0] iData = '0;
            logic ifEarly = 1'b0;
            dReq[0] = 1'b1; dWe[0] = 1'b0; dAddr[0] = 32'h20;
            ifReq[0] = 1'b1; ifAddr[0] = 32'hC;
            for (int c = 0; c < 20; c++) begin
                #1;
                if (dReady[0] && dCyc < 0) begin
                    dCyc = c; dData = dRdata[0]; dReq[0] = 1'b0;
                end
                if (ifReady[0] && iCyc < 0) begin
                    iCyc = c; iData = ifRdata[0]; ifReq[0] = 1'b0;
                    if (dCyc < 0) ifEarly = 1'b1;
                end
                tick();
            end
            checkOutput("conflict dReady cycle", 32'(dCyc), 32'd2);
            checkOutput("conflict ifReady cycle", 32'(iCyc), 32'd5);
            checkOutput("conflict dRdata", dData, 32'h2008_0011);
            checkOutput("conflict ifRdata", iData, 32'h2003_0007);
            checkOutput("conflict fetch before data", 32'(ifEarly), 32'd0);
        end

        // Back-to-back fetches with IfReq held, WAIT_CYCLES=0.
        begin
            int k = 0;
            logic [31:0] addr = 32'h0;
            ifReq[0] = 1'b1; ifAddr[0] = addr;
            for (int c = 0; c < 20; c++) begin
                #1;
                if (ifReady[0]) begin
                    checkOutput($sformatf("b2b%0d cycle", k), 32'(c), 32'(2 + 3 * k));
                    checkOutput($sformatf("b2b%0d ifRdata", k), ifRdata[0], initWord(int'(addr >> 2)));
                    k++;
                    addr = addr + 32'd4;
                    ifAddr[0] = addr;
                    if (k == 3) ifReq[0] = 1'b0;
                end
                tick();
            end
            checkOutput("b2b count", 32'(k), 32'd3);
        end

        // Reset during a store with cnt=1 (WAIT_CYCLES=2), then read the location back.
        begin
            logic sawWe = 1'b0;
            logic sawReady = 1'b0;
            int rCyc = -1;
            logic [31:0] rData = '0;
            dReq[2] = 1'b1; dWe[2] = 1'b1; dAddr[2] = 32'h30; dWdata[2] = 32'hCAFE_F00D;
            for (int c = 0; c < 3; c++) begin
                if (c == 2) reset[2] = 1'b1;
                #1;
                sawWe = sawWe | memWe[2];
                sawReady = sawReady | dReady[2];
                tick();
            end
            reset[2] = 1'b0; dReq[2] = 1'b0; dWe[2] = 1'b0; dWdata[2] = '0;
            #1;
            checkOutput("rst busyD", 32'(busyD[2]), 32'd0);
            checkOutput("rst memAddr", memAddr[2], 32'd0);
            checkOutput("rst memWdata", memWdata[2], 32'd0);
            for (int c = 0; c < 5; c++) begin
                #1;
                sawWe = sawWe | memWe[2];
                sawReady = sawReady | dReady[2];
                tick();
            end
            checkOutput("rst memWe seen", 32'(sawWe), 32'd0);
            checkOutput("rst dReady seen", 32'(sawReady), 32'd0);

            dReq[2] = 1'b1; dWe[2] = 1'b0; dAddr[2] = 32'h30;
            for (int c = 0; c < 15; c++) begin
                #1;
                if (dReady[2] && rCyc < 0) begin
                    rCyc = c; rData = dRdata[2]; dReq[2] = 1'b0;
                end
                tick();
            end
            checkOutput("rst readback cycle", 32'(rCyc), 32'd4);
            checkOutput("rst readback data", rData, 32'h200C_0019);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the pipeline's instruction-fetch port and its data-memory (MEM-stage) port.
- Sequences each access through a fixed number of wait states.
- Returns a one-cycle ready pulse, plus registered read data, to the winning requester.
- Sits between the pipelined CPU core and the memory. It also produces stall hints that the hazard logic uses to freeze the fetch and memory stages while an access is pending.

Parameters:
- WAIT_CYCLES, 1, extra memory cycles per access; legal range 0..15; 4-bit down-counter.

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- IfReq  in  1  fetch request, level; held until IfReady
- IfAddr  in  32  fetch byte address
- IfRdata  out  32  fetched word, registered
- IfReady  out  1  one-cycle completion pulse, fetch
- DReq  in  1  data request, level; held until DReady
- DWe  in  1  1 = store, 0 = load
- DAddr  in  32  data byte address
- DWdata  in  32  store data
- DRdata  out  32  load word, registered
- DReady  out  1  one-cycle completion pulse, data
- MemAddr  out  32  word-aligned memory address
- MemWe  out  1  memory write strobe
- MemWdata  out  32  memory write data
- MemRdata  in  32  memory read data, combinational from MemAddr
- StallF  out  1  IfReq & ~IfReady (combinational)
- StallM  out  1  DReq & ~DReady (combinational)
- BusyD  out  1  high while the FSM is in BUSY_D or DONE_D

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- Reset values: state IDLE, cnt 0, IfReady = DReady = 0, IfRdata = DRdata = 0, MemAddr = 0, MemWe = 0, MemWdata = 0.
- Reset mid-access aborts the access at the next edge. No ready is issued, no write occurs after that edge, and latched request data is discarded.
- IDLE arbitration uses fixed priority, data before fetch (the MEM stage holds the older instruction).
  - DReq=1: latch DAddr, DWe, DWdata; cnt <= WAIT_CYCLES; go to BUSY_D.
  - Else IfReq=1: latch IfAddr; cnt <= WAIT_CYCLES; go to BUSY_I.
  - Else stay in IDLE.
- BUSY_x:
  - MemAddr = {latched_addr[31:2], 2'b00}; addr[1:0] is ignored.
  - MemWdata = latched data.
  - If cnt != 0: cnt <= cnt - 1.
  - If cnt == 0 (the final access cycle): MemWe = latched DWe (BUSY_D only). For loads, MemRdata is captured into DRdata/IfRdata at this edge. Go to DONE_x.
- MemWe is high for exactly one cycle per store and never in BUSY_I, DONE_x or IDLE.
- DONE_x: x-Ready = 1 for exactly this cycle. New requests are ignored here and the FSM goes to IDLE. The requester drops or changes its request at the edge ending DONE, so no stale request is re-granted.
- Rdata registers hold their value until the next completed load on the same port. A store does not change DRdata.
- Latency: request first seen in IDLE at cycle t → access cycles t+1..t+1+WAIT_CYCLES → Ready at t+2+WAIT_CYCLES.
  - Back-to-back grants are separated by one IDLE cycle.
  - Occupancy per access is WAIT_CYCLES+3 cycles.
- Simultaneous DReq and IfReq: data is served first. Fetch is granted at the following IDLE if IfReq is still high. Fetch can starve only while the MEM stage issues consecutive requests, which the pipeline bounds.
- Request inputs that change during BUSY/DONE have no effect; the latched values are used.
- Outside BUSY states, MemAddr/MemWdata keep their last value and MemWe = 0.

Test Plan:
- Reset, then idle: no requests for 10 cycles → MemWe=0, both Ready=0, Rdata=0.
- Fetch, WAIT_CYCLES=1: IfReq=1, IfAddr=0x0000_0008, MemRdata returns 0x2002_0005 for addr 8 → IfReady high exactly at cycle t+3, IfRdata=0x2002_0005, StallF=1 for cycles t..t+2.
- Store then load: DReq/DWe=1, DAddr=0x54, DWdata=0xDEAD_BEEF → MemWe high in one cycle with MemAddr=0x54. Then a load from 0x57 → MemAddr=0x54, DRdata=0xDEAD_BEEF, DReady pulse.
- Conflict: IfReq and DReq rise together, WAIT_CYCLES=0 → DReady at t+2; fetch is granted in the IDLE after DONE_D, so IfReady comes at t+5, never before DReady.
- Reset mid-store: Reset asserted during BUSY_D with cnt=1 (WAIT_CYCLES=2) → no MemWe pulse, no DReady, and state is IDLE after the reset edge.
- WAIT_CYCLES=0 back-to-back fetches with IfReq held and IfAddr advancing 0,4,8 → IfReady every 3 cycles with matching data.
